alu8_arbiter: RTL

- Round-robin arbiter and sequencer that shares one alu8 instance among NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the ALU operand/op_code inputs.
- Waits out the ALU's registered latency, captures result and carry, and returns them with the requester ID over a valid/ready response channel.
- Sits between the command sources (test sequencer, microcode units) and the alu8 datapath.

---
 rtl/alu8_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu8_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-latency alu8 among NUM_REQ requesters.
// One request in flight at a time; results return with the requester ID over valid/ready.
module alu8_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op_code,
    input  logic [8*NUM_REQ-1:0] req_operand_1,
    input  logic [8*NUM_REQ-1:0] req_operand_2,
    input  logic [3*NUM_REQ-1:0] req_shift_rotate,
    output logic [3:0]           alu_op_code,
    output logic [7:0]           alu_operand_1,
    output logic [7:0]           alu_operand_2,
    output logic [2:0]           alu_shift_rotate,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_error
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_op_code_q, alu_op_code_d;
    logic [7:0]       alu_operand_1_q, alu_operand_1_d;
    logic [7:0]       alu_operand_2_q, alu_operand_2_d;
    logic [2:0]       alu_shift_rotate_q, alu_shift_rotate_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_error_q, rsp_error_d;

    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W-1:0]    win_id;
    logic [3:0]         win_op;
    logic [7:0]         win_a;
    logic [7:0]         win_b;
    logic [2:0]         win_sh;
    logic               win_legal;

    // Pass 0 scans indices at/after the pointer, pass 1 the wrapped indices below it.
    always_comb begin
        win_found  = 1'b0;
        win_onehot = '0;
        win_id     = '0;
        win_op     = '0;
        win_a      = '0;
        win_b      = '0;
        win_sh     = '0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[i] && ((pass == 0) == (i >= 32'(ptr_q)))) begin
                    win_found     = 1'b1;
                    win_onehot[i] = 1'b1;
                    win_id        = ID_W'(i);
                    win_op        = req_op_code[4*i +: 4];
                    win_a         = req_operand_1[8*i +: 8];
                    win_b         = req_operand_2[8*i +: 8];
                    win_sh        = req_shift_rotate[3*i +: 3];
                end
            end
        end
        win_legal = (win_op >= 4'd1) && (win_op <= 4'd9);
    end

    assign req_ready = (state_q == IDLE) ? win_onehot : '0;

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        id_d               = id_q;
        cnt_d              = cnt_q;
        alu_op_code_d      = alu_op_code_q;
        alu_operand_1_d    = alu_operand_1_q;
        alu_operand_2_d    = alu_operand_2_q;
        alu_shift_rotate_d = alu_shift_rotate_q;
        rsp_valid_d        = rsp_valid_q;
        rsp_id_d           = rsp_id_q;
        rsp_result_d       = rsp_result_q;
        rsp_carry_d        = rsp_carry_q;
        rsp_error_d        = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    alu_op_code_d      = win_op;
                    alu_operand_1_d    = win_a;
                    alu_operand_2_d    = win_b;
                    alu_shift_rotate_d = win_sh;
                    id_d               = win_id;
                    ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    if (win_legal) begin
                        state_d = ISSUE;
                    end else begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = win_id;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_error_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ALU_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = alu_result;
                    // An unknown carry resolves to 0 through the if.
                    rsp_carry_d  = 1'b0;
                    if (alu_carry == 1'b1) rsp_carry_d = 1'b1;
                    rsp_error_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            ptr_q              <= '0;
            id_q               <= '0;
            cnt_q              <= '0;
            alu_op_code_q      <= '0;
            alu_operand_1_q    <= '0;
            alu_operand_2_q    <= '0;
            alu_shift_rotate_q <= '0;
            rsp_valid_q        <= 1'b0;
            rsp_id_q           <= '0;
            rsp_result_q       <= '0;
            rsp_carry_q        <= 1'b0;
            rsp_error_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            ptr_q              <= ptr_d;
            id_q               <= id_d;
            cnt_q              <= cnt_d;
            alu_op_code_q      <= alu_op_code_d;
            alu_operand_1_q    <= alu_operand_1_d;
            alu_operand_2_q    <= alu_operand_2_d;
            alu_shift_rotate_q <= alu_shift_rotate_d;
            rsp_valid_q        <= rsp_valid_d;
            rsp_id_q           <= rsp_id_d;
            rsp_result_q       <= rsp_result_d;
            rsp_carry_q        <= rsp_carry_d;
            rsp_error_q        <= rsp_error_d;
        end
    end

    assign alu_op_code      = alu_op_code_q;
    assign alu_operand_1    = alu_operand_1_q;
    assign alu_operand_2    = alu_operand_2_q;
    assign alu_shift_rotate = alu_shift_rotate_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_carry        = rsp_carry_q;
    assign rsp_error        = rsp_error_q;

endmodule
